// File: rtl/pri_irq_ctrl8_pkg.sv
// Shared constants, state type and helpers for the pri_irq_ctrl8 interrupt controller.
package pri_irq_ctrl8_pkg;

    // Number of request lines and width of the encoded index.
    localparam int IRQ_N      = 8;
    localparam int IRQ_CODE_W = 3;

    // Presentation state: IDLE waits for an eligible request, PRESENT holds a grant
    // on the output until the consumer accepts it.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

    // One-hot expansion of a request index, used to build the pending-clear vector.
    function automatic logic [IRQ_N-1:0] onehot8(input logic [IRQ_CODE_W-1:0] code);
        logic [IRQ_N-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pri_irq_ctrl8_prienc.sv
// PriorityEncode8: 8-input priority encoder, highest set index wins.
// code is the index of the highest set input bit; z is 1 when no input bit is set
// (code is 0 in that case).
module PriorityEncode8 (
    input  logic [7:0] in,
    output logic [2:0] code,
    output logic       z
);

    // Scan upward so the highest set bit is the last assignment and wins.
    always_comb begin
        code = 3'd0;
        z    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in[i]) begin
                code = 3'(i);
                z    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pri_irq_ctrl8.sv
// pri_irq_ctrl8: captures eight request lines into a pending register, arbitrates
// the masked pending set through PriorityEncode8 and presents the winning index
// over a valid/ready handshake, clearing the serviced pending bit on acceptance.
//
// Handshake: irq_valid/irq_code form the producer side. Once irq_valid is high,
// irq_code is frozen and irq_valid stays high until a clock edge where irq_ready
// is also high; that edge is the transfer. irq_valid is never withdrawn without a
// transfer except by reset. After a transfer the controller spends one cycle in
// IDLE before it can present again, so the peak rate is one grant per two cycles.
module pri_irq_ctrl8
    import pri_irq_ctrl8_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IRQ_N-1:0]      req,
    input  logic [IRQ_N-1:0]      mask,
    output logic                  irq_valid,
    output logic [IRQ_CODE_W-1:0] irq_code,
    input  logic                  irq_ready,
    output logic [IRQ_N-1:0]      pending,
    output logic                  pending_none,
    output logic [CNT_W-1:0]      grant_count,
    output logic [0:0]            dbg_state
);

    // State encodings kept as plain constants so the state register is a simple vector.
    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_PRESENT = PRESENT;

    // Registered state and next-state values.
    logic [IRQ_N-1:0]      req_q;
    logic [IRQ_N-1:0]      pending_q,  pending_d;
    logic [IRQ_CODE_W-1:0] code_q,     code_d;
    logic [0:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    // Combinational helpers.
    logic [IRQ_N-1:0]      set_v;
    logic [IRQ_N-1:0]      clr_v;
    logic [IRQ_N-1:0]      eligible;
    logic [IRQ_CODE_W-1:0] enc_code;
    logic                  enc_z;
    logic                  accept;

    // Only unmasked pending lines take part in arbitration; masked ones just accumulate.
    assign eligible = pending_q & mask;

    PriorityEncode8 u_enc (
        .in   (eligible),
        .code (enc_code),
        .z    (enc_z)
    );

    // Transfer happens on any edge where the grant is shown and the consumer is ready.
    assign accept = (state_q == ST_PRESENT) && irq_ready;

    // Request capture: edge mode sets on a 0->1 transition, level mode while high.
    // A set on the same bit as a clear wins, so a fresh request is never lost.
    always_comb begin
        set_v     = EDGE_MODE ? (req & ~req_q) : req;
        clr_v     = accept ? onehot8(code_q) : '0;
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    // Presentation FSM: latch the winner when idle, hold it frozen until accepted.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!enc_z) begin
                    code_d  = enc_code;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything so a request held through reset
    // release shows up as a rising edge on the first clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            code_q    <= code_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign irq_valid    = (state_q == ST_PRESENT);
    assign irq_code     = code_q;
    assign pending      = pending_q;
    assign pending_none = enc_z;
    assign grant_count  = cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pri_irq_ctrl8.sv
// Self-checking bench for pri_irq_ctrl8 (edge mode, 8-bit grant counter).
module tb_pri_irq_ctrl8;

    localparam bit EDGE = 1'b1;
    localparam int CW   = 8;

    // Clock / reset
    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    req;
    logic [7:0]    mask;
    logic          irq_ready;
    logic          irq_valid;
    logic [2:0]    irq_code;
    logic [7:0]    pending;
    logic          pending_none;
    logic [CW-1:0] grant_count;
    logic [0:0]    dbg_state;

    always #5 clk = ~clk;

    pri_irq_ctrl8 #(.EDGE_MODE(EDGE), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mask         (mask),
        .irq_valid    (irq_valid),
        .irq_code     (irq_code),
        .irq_ready    (irq_ready),
        .pending      (pending),
        .pending_none (pending_none),
        .grant_count  (grant_count),
        .dbg_state    (dbg_state)
    );

    // Counters
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the controller should hold after the last clock edge.
    logic [7:0] m_pending;
    logic [7:0] m_reqq;
    bit         m_valid;
    int         m_code;
    int         m_count;
    int         total_grants;

    // Scoreboard: granted indices waiting for their handshake, and observed handshakes.
    logic [2:0] exp_q[$];
    logic [2:0] seen_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Highest set index, -1 when none.
    function automatic int top_index(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pending    = 8'h00;
        m_reqq       = 8'h00;
        m_valid      = 1'b0;
        m_code       = 0;
        m_count      = 0;
        total_grants = 0;
        exp_q.delete();
    endtask

    // Advance the model over one clock edge with the inputs that were applied.
    task automatic model_clock(input logic [7:0] r, input logic [7:0] m, input logic rdy);
        logic [7:0] set_v;
        logic [7:0] clr_v;
        int         win;
        set_v = EDGE ? (r & ~m_reqq) : r;
        clr_v = 8'h00;
        win   = top_index(m_pending & m);
        if (m_valid) begin
            if (rdy) begin
                clr_v[m_code] = 1'b1;
                m_valid       = 1'b0;
                m_count       = (m_count + 1) % (1 << CW);
                total_grants++;
            end
        end else if (win >= 0) begin
            m_code  = win;
            m_valid = 1'b1;
            exp_q.push_back(3'(win));
        end
        m_pending = (m_pending & ~clr_v) | set_v;
        m_reqq    = r;
    endtask

    task automatic compare_all();
        check("valid", irq_valid, m_valid);
        if (m_valid) check("code", irq_code, m_code);
        check("pending", pending, m_pending);
        check("pending_none", pending_none, (m_pending & mask) == 8'h00);
        check("grant_count", grant_count, m_count);
        check("state", dbg_state, m_valid);
    endtask

    // Driver: called at a falling edge; applies inputs, checks, then runs one clock.
    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rdy);
        req       = r;
        mask      = m;
        irq_ready = rdy;
        #1;
        compare_all();
        if (irq_valid && rdy) begin
            seen_q.push_back(irq_code);
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check("sb_code", irq_code, exp_q.pop_front());
        end
        @(posedge clk);
        model_clock(r, m, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] r);
        reset     = 1'b1;
        req       = r;
        mask      = 8'hFF;
        irq_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", irq_valid, 0);
        check("rst_pending", pending, 0);
        check("rst_count", grant_count, 0);
        check("rst_code", irq_code, 0);
        reset = 1'b0;
        model_reset();
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with all requests held high
        do_reset(8'hFF);
        step(8'hFF, 8'hFF, 1'b0);
        step(8'hFF, 8'hFF, 1'b0);
        #1;
        check("t1_valid", irq_valid, 1);
        check("t1_code", irq_code, 3'd7);
        check("t1_pending", pending, 8'hFF);

        // 2: priority order with ready held high
        seen_q.delete();
        repeat (16) step(8'hFF, 8'hFF, 1'b1);
        check("t2_ngrants", seen_q.size(), 8);
        for (int i = 0; i < 8 && i < seen_q.size(); i++) check("t2_order", seen_q[i], 7 - i);
        #1;
        check("t2_pending", pending, 8'h00);
        check("t2_none", pending_none, 1);
        check("t2_count", grant_count, 8);

        // 3: code freeze while a higher request arrives
        step(8'h00, 8'hFF, 1'b0);
        step(8'h04, 8'hFF, 1'b0);
        step(8'h04, 8'hFF, 1'b0);
        step(8'h04, 8'hFF, 1'b0);
        step(8'h44, 8'hFF, 1'b0);
        step(8'h44, 8'hFF, 1'b0);
        step(8'h44, 8'hFF, 1'b0);
        #1;
        check("t3_hold_valid", irq_valid, 1);
        check("t3_hold_code", irq_code, 3'd2);
        seen_q.delete();
        step(8'h44, 8'hFF, 1'b1);
        step(8'h44, 8'hFF, 1'b1);
        step(8'h44, 8'hFF, 1'b1);
        check("t3_ngrants", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("t3_first", seen_q[0], 3'd2);
            check("t3_second", seen_q[1], 3'd6);
        end
        step(8'h00, 8'hFF, 1'b1);

        // 4: new edge on bit 3 lands on the acceptance of code 3
        step(8'h08, 8'hFF, 1'b0);
        step(8'h08, 8'hFF, 1'b0);
        step(8'h00, 8'hFF, 1'b0);
        step(8'h08, 8'hFF, 1'b1);
        #1;
        check("t4_pending3", pending[3], 1);
        check("t4_idle", irq_valid, 0);
        step(8'h08, 8'hFF, 1'b0);
        #1;
        check("t4_regrant_valid", irq_valid, 1);
        check("t4_regrant_code", irq_code, 3'd3);
        step(8'h08, 8'hFF, 1'b1);
        step(8'h00, 8'hFF, 1'b1);

        // 5: masking
        step(8'h81, 8'h01, 1'b1);
        step(8'h81, 8'h01, 1'b1);
        step(8'h81, 8'h01, 1'b1);
        step(8'h81, 8'h01, 1'b1);
        #1;
        check("t5_pending", pending, 8'h80);
        check("t5_none", pending_none, 1);
        check("t5_valid", irq_valid, 0);
        step(8'h81, 8'h80, 1'b0);
        #1;
        check("t5_unmask_valid", irq_valid, 1);
        check("t5_unmask_code", irq_code, 3'd7);
        step(8'h81, 8'h80, 1'b1);
        step(8'h00, 8'hFF, 1'b1);

        // 6: asynchronous reset while presenting
        step(8'h10, 8'hFF, 1'b0);
        step(8'h10, 8'hFF, 1'b0);
        #1;
        check("t6_pre_valid", irq_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_valid", irq_valid, 0);
        check("t6_async_pending", pending, 0);
        check("t6_async_count", grant_count, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Grant counter wrap after 256 grants
        for (int c = 0; c < 3000 && total_grants < 256; c++) begin
            step(((c % 2) == 0) ? 8'hFF : 8'h00, 8'hFF, 1'b1);
        end
        check("wrap_grants", total_grants, 256);
        #1;
        check("wrap_count", grant_count, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [7:0] r;
            logic [7:0] m;
            r = 8'($urandom_range(0, 255));
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
            step(r, m, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
